// File: rtl/rr_quantum_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grants.
// Define RRA_QUANTUM_PREEMPT_EN to enable quantum (time-slice) preemption of the holder.
module rr_quantum_arbiter #(
    parameter int unsigned QUANTUM = 10,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req3,
    input  logic req2,
    input  logic req1,
    input  logic req0,
    output logic gnt3,
    output logic gnt2,
    output logic gnt1,
    output logic gnt0
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] req;
    logic [3:0] others;

    if (QUANTUM < 1 || QUANTUM > 255 || (2 ** CNT_W) <= QUANTUM) begin : g_bad_param
        $error("rr_quantum_arbiter: QUANTUM must be 1..255 and fit in CNT_W bits");
    end

    assign req    = {req3, req2, req1, req0};
    assign others = req & ~(4'b0001 << owner_q);

    // First requester found searching upward from base+1, wrapping back to base last.
    function automatic logic [1:0] next_idx(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        next_idx = base;
        found    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && r[idx]) begin
                next_idx = idx;
                found    = 1'b1;
            end
        end
    endfunction

`ifdef RRA_QUANTUM_PREEMPT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef RRA_QUANTUM_PREEMPT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StBusy;
                    owner_d = next_idx(req, ptr_q);
`ifdef RRA_QUANTUM_PREEMPT_EN
                    cnt_d   = CNT_W'(1);
`endif
                end
            end
            StBusy: begin
                if (!req[owner_q]) begin
                    ptr_d = owner_q;
                    if (|others) begin
                        owner_d = next_idx(others, owner_q);
`ifdef RRA_QUANTUM_PREEMPT_EN
                        cnt_d   = CNT_W'(1);
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end
`ifdef RRA_QUANTUM_PREEMPT_EN
                else if (cnt_q == CNT_W'(QUANTUM)) begin
                    // Expiry: hand off if anyone waits, otherwise start a fresh quantum.
                    cnt_d = CNT_W'(1);
                    if (|others) begin
                        ptr_d   = owner_q;
                        owner_d = next_idx(others, owner_q);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = StIdle;
        endcase
        gnt_d = (state_d == StBusy) ? (4'b0001 << owner_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= 2'd0;
            ptr_q   <= 2'd3;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    assign {gnt3, gnt2, gnt1, gnt0} = gnt_q;

endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// Directed self-checking bench for rr_quantum_arbiter; expectations follow RRA_QUANTUM_PREEMPT_EN.
module tb_rr_quantum_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    int         checks;
    int         errors;

    rr_quantum_arbiter #(
        .QUANTUM(10),
        .CNT_W  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req3(req[3]),
        .req2(req[2]),
        .req1(req[1]),
        .req0(req[0]),
        .gnt3(gnt[3]),
        .gnt2(gnt[2]),
        .gnt1(gnt[1]),
        .gnt0(gnt[0])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    task automatic expect_gnt(input string name, input int cyc, input logic [3:0] exp);
        checks++;
        if (gnt !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: gnt=%b expected %b", name, cyc, gnt, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'b0000;
        #12;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset: gnt=%b expected 0000", gnt);
        end
        #18;
        rst = 1'b1;
        step();
        expect_gnt("reset_idle", 0, 4'b0000);
    endtask

    // req0 alone for 22 cycles: quantum renews with no contention.
    task automatic test_solo();
        req = 4'b0001;
        for (int c = 1; c <= 22; c++) begin
            step();
            expect_gnt("solo_hold", c, 4'b0001);
        end
        req = 4'b0000;
        step();
        expect_gnt("solo_release", 0, 4'b0000);
    endtask

    task automatic test_sequential();
        int len [3] = '{24, 26, 22};
        for (int m = 1; m <= 3; m++) begin
            req = oh(m);
            for (int c = 1; c <= len[m-1]; c++) begin
                step();
                expect_gnt("seq_hold", c, oh(m));
                checks++;
                if ($countones(gnt) > 1) begin
                    errors++;
                    $display("FAIL seq_onehot cycle %0d: gnt=%b expected at most one bit", c, gnt);
                end
            end
            req = 4'b0000;
            step();
            expect_gnt("seq_gap", m, 4'b0000);
        end
    endtask

    // Pointer is 3 here, so rotation starts at master 0.
    task automatic test_contention();
        logic [3:0] exp;
        req = 4'b1111;
        for (int c = 1; c <= 50; c++) begin
            step();
`ifdef RRA_QUANTUM_PREEMPT_EN
            exp = oh(((c - 1) / 10) % 4);
`else
            exp = 4'b0001;
`endif
            expect_gnt("contention", c, exp);
        end
        req = 4'b0000;
        step();
        expect_gnt("contention_end", 0, 4'b0000);
    endtask

    // Pointer is 0: master 1 wins, drops after 3 cycles, master 2 gets a full quantum.
    task automatic test_early_release();
        logic [3:0] exp;
        req = 4'b1110;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c <= 3) exp = 4'b0010;
`ifdef RRA_QUANTUM_PREEMPT_EN
            else if (c <= 13) exp = 4'b0100;
            else exp = 4'b1000;
`else
            else exp = 4'b0100;
`endif
            expect_gnt("early_release", c, exp);
            if (c == 3) req = 4'b1100;
        end
        req = 4'b0000;
        step();
        expect_gnt("early_release_end", 0, 4'b0000);
    endtask

    task automatic test_mid_reset();
        req = 4'b0100;
        step();
        step();
        expect_gnt("midrst_pre", 0, 4'b0100);
        #2;
        rst = 1'b0;
        #1;
        expect_gnt("midrst_async", 0, 4'b0000);
        req = 4'b0101;
        step();
        expect_gnt("midrst_held", 0, 4'b0000);
        rst = 1'b1;
        step();
        expect_gnt("midrst_prio", 1, 4'b0001);
        req = 4'b0000;
        step();
        expect_gnt("midrst_end", 0, 4'b0000);
    endtask

    // Fresh reset so master 0 has priority, then req0+req1 for 30 cycles.
    task automatic test_two_holders();
        logic [3:0] exp;
        rst = 1'b0;
        #3;
        rst = 1'b1;
        req = 4'b0011;
        for (int c = 1; c <= 30; c++) begin
            step();
`ifdef RRA_QUANTUM_PREEMPT_EN
            exp = ((c - 1) / 10 == 1) ? 4'b0010 : 4'b0001;
`else
            exp = 4'b0001;
`endif
            expect_gnt("two_hold", c, exp);
        end
        req = 4'b0010;
        step();
        expect_gnt("two_handoff", 0, 4'b0010);
        req = 4'b0000;
        step();
        expect_gnt("two_end", 0, 4'b0000);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        req    = 4'b0000;
        test_reset();
        test_solo();
        test_sequential();
        test_contention();
        test_early_release();
        test_mid_reset();
        test_two_holders();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
